// File: rtl/data_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_pkg
// Description : Shared constants, types and address helpers for the data
//               cache memory responder and its refill word counter.
// Revision    : 1.0 - initial release
// ============================================================================
package data_cache_pkg;

    localparam int PORT_WIDTH    = 32;
    localparam int ADDR_WIDTH    = 32;
    localparam int BLOCK_WORDS   = 4;
    localparam int WORD_IDX_W    = $clog2(BLOCK_WORDS);
    localparam int LINE_OFFSET_W = WORD_IDX_W + 2;

    typedef logic [ADDR_WIDTH-1:0] data_cache_addr_t;
    typedef logic [PORT_WIDTH-1:0] data_cache_word_t;
    typedef logic [WORD_IDX_W-1:0] data_cache_widx_t;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_REFILL_ISSUE = 3'd1,
        ST_REFILL_DRAIN = 3'd2,
        ST_WRITEBACK    = 3'd3,
        ST_INVALIDATE   = 3'd4
    } responder_state_t;

    // Clear the byte and word-in-line offset bits.
    function automatic data_cache_addr_t line_base(input data_cache_addr_t a);
        return a & ~data_cache_addr_t'((1 << LINE_OFFSET_W) - 1);
    endfunction

    // Clear only the byte offset bits.
    function automatic data_cache_addr_t word_align(input data_cache_addr_t a);
        return a & ~data_cache_addr_t'(3);
    endfunction

    // Base is line aligned, so OR-ing in the word index is an exact add.
    function automatic data_cache_addr_t word_addr(input data_cache_addr_t base,
                                                   input data_cache_widx_t idx);
        return base | (data_cache_addr_t'(idx) << 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_cache_refill_counter.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_refill_counter
// Description : Word index and issue counter for one cache line refill.
//               load_i presets the word index to start_i and clears the issue
//               count; advance_i steps both. The word index wraps modulo
//               BLOCK_WORDS so a critical-word-first burst wraps naturally.
// Ports       : clk_i, rst_i       clock, synchronous active-high reset
//               load_i, start_i    begin a new line at word start_i
//               advance_i          one word issued this cycle
//               word_idx_o         word index to issue now
//               first_o / last_o   first / last word of the line
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache_refill_counter
    import data_cache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [WORD_IDX_W-1:0] start_i,
    input  logic                  advance_i,
    output logic [WORD_IDX_W-1:0] word_idx_o,
    output logic                  first_o,
    output logic                  last_o
);

    localparam logic [WORD_IDX_W-1:0] C_LAST_COUNT = WORD_IDX_W'(BLOCK_WORDS - 1);

    logic [WORD_IDX_W-1:0] word_q;
    logic [WORD_IDX_W-1:0] issued_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            word_q   <= '0;
            issued_q <= '0;
        end else if (load_i) begin
            word_q   <= start_i;
            issued_q <= '0;
        end else if (advance_i) begin
            word_q   <= word_q + 1'b1;
            issued_q <= issued_q + 1'b1;
        end
    end

    assign word_idx_o = word_q;
    assign first_o    = (issued_q == '0);
    assign last_o     = (issued_q == C_LAST_COUNT);

endmodule
`default_nettype wire

// File: rtl/data_cache_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_cache_memory_responder
// Description : Memory-side end of the data cache interface. Serves line
//               refills from a 1-cycle-latency backing memory, absorbs
//               single-word writebacks and forwards snoop invalidations to
//               the cache. One request at a time; in IDLE a snoop beats a
//               writeback, which beats a refill.
// Config      : REFILL_CRITICAL_WORD_FIRST_EN - refill starts at the requested
//               word and wraps; otherwise always word 0 upwards.
// Ports       : clk_i/rst_i            clock, synchronous active-high reset
//               cache_request_*        refill request, ack, data, valids
//               cache_writeback_*      writeback word and ready
//               snoop_* / cache_invalidate_*  invalidate forwarding handshake
//               mem_*                  backing memory strobes, address, data
// Revision    : 1.0 - initial release
// ============================================================================
module data_cache_memory_responder
    import data_cache_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cache_request_i,
    input  logic [ADDR_WIDTH-1:0] cache_request_address_i,
    output logic                  cache_acknowledge_o,
    output logic [PORT_WIDTH-1:0] cache_data_o,
    output logic                  cache_data_valid_o,
    output logic                  cache_line_valid_o,
    input  logic                  cache_writeback_i,
    input  logic [ADDR_WIDTH-1:0] cache_writeback_address_i,
    input  logic [PORT_WIDTH-1:0] cache_writeback_data_i,
    output logic                  cache_writeback_ready_o,
    input  logic                  snoop_invalidate_i,
    input  logic [ADDR_WIDTH-1:0] snoop_address_i,
    output logic                  snoop_ready_o,
    output logic                  cache_invalidate_o,
    output logic [ADDR_WIDTH-1:0] cache_invalidate_address_o,
    input  logic                  cache_invalidate_ack_i,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic [PORT_WIDTH-1:0] mem_write_data_o,
    input  logic [PORT_WIDTH-1:0] mem_read_data_i
);

    responder_state_t state_q, state_d;
    data_cache_addr_t addr_q, addr_d;     // refill base, writeback or snoop address
    data_cache_word_t wdata_q, wdata_d;
    logic             rd_pend_q;          // a read was issued last cycle
    logic             line_last_q;        // ...and it was the last of the line

    logic             cnt_load;
    logic             cnt_adv;
    data_cache_widx_t cnt_start;
    data_cache_widx_t cnt_idx;
    logic             cnt_first;
    logic             cnt_last;

`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    assign cnt_start = cache_request_address_i[LINE_OFFSET_W-1:2];
`else
    assign cnt_start = '0;
`endif

    data_cache_refill_counter u_refill_counter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .start_i    (cnt_start),
        .advance_i  (cnt_adv),
        .word_idx_o (cnt_idx),
        .first_o    (cnt_first),
        .last_o     (cnt_last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_pend_q   <= 1'b0;
            line_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_pend_q   <= mem_read_o;
            line_last_q <= mem_read_o & cnt_last;
        end
    end

    always_comb begin
        state_d                    = state_q;
        addr_d                     = addr_q;
        wdata_d                    = wdata_q;
        cnt_load                   = 1'b0;
        cnt_adv                    = 1'b0;
        cache_acknowledge_o        = 1'b0;
        cache_writeback_ready_o    = 1'b0;
        snoop_ready_o              = 1'b0;
        cache_invalidate_o         = 1'b0;
        cache_invalidate_address_o = '0;
        mem_read_o                 = 1'b0;
        mem_write_o                = 1'b0;
        mem_address_o              = '0;
        mem_write_data_o           = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (snoop_invalidate_i) begin
                    addr_d  = snoop_address_i;
                    state_d = ST_INVALIDATE;
                end else if (cache_writeback_i) begin
                    addr_d  = word_align(cache_writeback_address_i);
                    wdata_d = cache_writeback_data_i;
                    state_d = ST_WRITEBACK;
                end else if (cache_request_i) begin
                    addr_d   = line_base(cache_request_address_i);
                    cnt_load = 1'b1;
                    state_d  = ST_REFILL_ISSUE;
                end
            end
            ST_REFILL_ISSUE: begin
                cache_acknowledge_o = cnt_first;
                mem_read_o          = 1'b1;
                mem_address_o       = word_addr(addr_q, cnt_idx);
                cnt_adv             = 1'b1;
                if (cnt_last) begin
                    state_d = ST_REFILL_DRAIN;
                end
            end
            ST_REFILL_DRAIN: begin
                // Only the final returning word remains; nothing to drive.
                state_d = ST_IDLE;
            end
            ST_WRITEBACK: begin
                mem_write_o             = 1'b1;
                mem_address_o           = addr_q;
                mem_write_data_o        = wdata_q;
                cache_writeback_ready_o = 1'b1;
                state_d                 = ST_IDLE;
            end
            ST_INVALIDATE: begin
                cache_invalidate_o         = 1'b1;
                cache_invalidate_address_o = addr_q;
                if (cache_invalidate_ack_i) begin
                    snoop_ready_o = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Memory read data returns one cycle after the strobe and passes straight
    // through; gated so the cache never sees stale bus values.
    assign cache_data_valid_o = rd_pend_q;
    assign cache_line_valid_o = line_last_q;
    assign cache_data_o       = rd_pend_q ? mem_read_data_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_data_cache_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_cache_memory_responder
// Description : Scoreboard bench for data_cache_memory_responder. Drivers act
//               1 time unit after the rising edge; the monitor samples on the
//               falling edge and pops expectations pushed by the drivers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_cache_memory_responder;
    import data_cache_pkg::*;

    localparam int BW  = BLOCK_WORDS;
    localparam int TMO = 200;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cache_request_i = 1'b0;
    logic [31:0] cache_request_address_i = '0;
    logic        cache_acknowledge_o;
    logic [31:0] cache_data_o;
    logic        cache_data_valid_o;
    logic        cache_line_valid_o;
    logic        cache_writeback_i = 1'b0;
    logic [31:0] cache_writeback_address_i = '0;
    logic [31:0] cache_writeback_data_i = '0;
    logic        cache_writeback_ready_o;
    logic        snoop_invalidate_i = 1'b0;
    logic [31:0] snoop_address_i = '0;
    logic        snoop_ready_o;
    logic        cache_invalidate_o;
    logic [31:0] cache_invalidate_address_o;
    logic        cache_invalidate_ack_i = 1'b0;
    logic        mem_read_o;
    logic        mem_write_o;
    logic [31:0] mem_address_o;
    logic [31:0] mem_write_data_o;
    logic [31:0] mem_read_data_i = '0;

    data_cache_memory_responder dut (
        .clk_i                      (clk_i),
        .rst_i                      (rst_i),
        .cache_request_i            (cache_request_i),
        .cache_request_address_i    (cache_request_address_i),
        .cache_acknowledge_o        (cache_acknowledge_o),
        .cache_data_o               (cache_data_o),
        .cache_data_valid_o         (cache_data_valid_o),
        .cache_line_valid_o         (cache_line_valid_o),
        .cache_writeback_i          (cache_writeback_i),
        .cache_writeback_address_i  (cache_writeback_address_i),
        .cache_writeback_data_i     (cache_writeback_data_i),
        .cache_writeback_ready_o    (cache_writeback_ready_o),
        .snoop_invalidate_i         (snoop_invalidate_i),
        .snoop_address_i            (snoop_address_i),
        .snoop_ready_o              (snoop_ready_o),
        .cache_invalidate_o         (cache_invalidate_o),
        .cache_invalidate_address_o (cache_invalidate_address_o),
        .cache_invalidate_ack_i     (cache_invalidate_ack_i),
        .mem_read_o                 (mem_read_o),
        .mem_write_o                (mem_write_o),
        .mem_address_o              (mem_address_o),
        .mem_write_data_o           (mem_write_data_o),
        .mem_read_data_i            (mem_read_data_i)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- backing memory (1-cycle read latency) ----------------
    function automatic logic [31:0] pat(input logic [31:0] a);
        return {16'hA0A0, a[15:2], 2'b00};
    endfunction

    logic [31:0] bmem [0:2047];
    initial for (int i = 0; i < 2048; i++) bmem[i] = pat(i * 4);

    always @(posedge clk_i) begin
        if (mem_read_o) mem_read_data_i <= bmem[mem_address_o[12:2]];
        else            mem_read_data_i <= $urandom;
        if (mem_write_o) bmem[mem_address_o[12:2]] <= mem_write_data_o;
    end

    // ---------------- scoreboard ----------------
    typedef struct { logic [31:0] data; logic last; } beat_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wb_t;

    beat_t       exp_beats[$];
    logic [31:0] exp_rdaddr[$];
    wb_t         exp_wb[$];
    logic [31:0] exp_snoop[$];
    byte         evlog[$];

    int errors = 0;
    int checks = 0;
    int beat_idx = 0, last_beat_cyc = 0, ack_cyc = -100;
    int ack_cnt = 0, refill_cnt = 0, inv_hi_cnt = 0, rdy_cnt = 0, wr_cnt = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference refill: plain line arithmetic, independent of RTL structure.
    task automatic push_refill(input logic [31:0] a);
        int unsigned first, base, widx;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
        first = (a / 4) % BW;
`else
        first = 0;
`endif
        base = a - (a % (BW * 4));
        for (int k = 0; k < BW; k++) begin
            beat_t b;
            widx   = (first + k) % BW;
            b.data = pat(base + 4 * widx);
            b.last = (k == BW - 1);
            exp_beats.push_back(b);
            exp_rdaddr.push_back(base + 4 * widx);
        end
        refill_cnt++;
    endtask

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (mem_read_o || mem_write_o)
                check("mem_strobe_exclusive", {mem_read_o, mem_write_o} & {mem_read_o, mem_write_o} == 2'b11, 0);
            if (cache_acknowledge_o) begin
                ack_cyc = cyc;
                ack_cnt++;
                evlog.push_back("R");
            end
            if (mem_read_o) begin
                if (exp_rdaddr.size() == 0) fail_now("unexpected_mem_read");
                else check("mem_read_addr", mem_address_o, exp_rdaddr.pop_front());
            end
            if (cache_data_valid_o) begin
                if (exp_beats.size() == 0) fail_now("unexpected_data_beat");
                else begin
                    beat_t b;
                    b = exp_beats.pop_front();
                    check("refill_data", cache_data_o, b.data);
                    check("line_valid", cache_line_valid_o, b.last);
                    if (beat_idx == 0) check("first_beat_latency", cyc, ack_cyc + 1);
                    else               check("beat_contiguous", cyc, last_beat_cyc + 1);
                    last_beat_cyc = cyc;
                    beat_idx = b.last ? 0 : beat_idx + 1;
                end
            end else begin
                check("data_gated", {cache_data_o, cache_line_valid_o}, 0);
            end
            if (mem_write_o || cache_writeback_ready_o) begin
                check("wb_ready_with_write", {mem_write_o, cache_writeback_ready_o}, 2'b11);
                wr_cnt++;
                evlog.push_back("W");
                if (exp_wb.size() == 0) fail_now("unexpected_write");
                else begin
                    wb_t w;
                    w = exp_wb.pop_front();
                    check("wb_addr", mem_address_o, w.addr);
                    check("wb_data", mem_write_data_o, w.data);
                end
            end
            if (cache_invalidate_o) inv_hi_cnt++;
            if (snoop_ready_o) begin
                rdy_cnt++;
                evlog.push_back("I");
                check("inv_level_at_ready", cache_invalidate_o, 1'b1);
                if (exp_snoop.size() == 0) fail_now("unexpected_snoop_ready");
                else check("inv_addr", cache_invalidate_address_o, exp_snoop.pop_front());
            end
        end
    end

    // ---------------- cache-side drivers ----------------
    task automatic refill(input logic [31:0] a, output int lat);
        bit got = 0;
        int req_cyc;
        @(posedge clk_i); #1;
        push_refill(a);
        cache_request_i = 1'b1;
        cache_request_address_i = a;
        req_cyc = cyc;
        lat = -1;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk_i);
            if (cache_acknowledge_o) begin got = 1; lat = cyc - req_cyc; break; end
        end
        if (!got) fail_now("refill_ack_timeout");
        @(posedge clk_i); #1;
        cache_request_i = 1'b0;
    endtask

    task automatic writeback(input logic [31:0] a, input logic [31:0] d);
        bit got = 0;
        wb_t w;
        @(posedge clk_i); #1;
        w.addr = {a[31:2], 2'b00};
        w.data = d;
        exp_wb.push_back(w);
        cache_writeback_i = 1'b1;
        cache_writeback_address_i = a;
        cache_writeback_data_i = d;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk_i);
            if (cache_writeback_ready_o) begin got = 1; break; end
        end
        if (!got) fail_now("writeback_timeout");
        @(posedge clk_i); #1;
        cache_writeback_i = 1'b0;
    endtask

    task automatic snoop(input logic [31:0] a, input int d);
        bit got = 0;
        @(posedge clk_i); #1;
        exp_snoop.push_back(a);
        snoop_invalidate_i = 1'b1;
        snoop_address_i = a;
        if (d == 0) cache_invalidate_ack_i = 1'b1;
        else begin
            for (int i = 0; i < TMO; i++) begin
                @(negedge clk_i);
                if (cache_invalidate_o) begin got = 1; break; end
            end
            if (!got) fail_now("invalidate_entry_timeout");
            repeat (d) @(posedge clk_i);
            #1;
            cache_invalidate_ack_i = 1'b1;
        end
        got = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk_i);
            if (snoop_ready_o) begin got = 1; break; end
        end
        if (!got) fail_now("snoop_ready_timeout");
        @(posedge clk_i); #1;
        snoop_invalidate_i = 1'b0;
        cache_invalidate_ack_i = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk_i);
            if (exp_beats.size() == 0 && exp_rdaddr.size() == 0 && exp_wb.size() == 0 &&
                exp_snoop.size() == 0 && !cache_data_valid_o) begin done = 1; break; end
        end
        if (!done) fail_now("drain_timeout");
        repeat (2) @(negedge clk_i);
    endtask

    function automatic logic [159:0] all_outputs();
        return {cache_acknowledge_o, cache_data_o, cache_data_valid_o, cache_line_valid_o,
                cache_writeback_ready_o, snoop_ready_o, cache_invalidate_o,
                cache_invalidate_address_o, mem_read_o, mem_write_o, mem_address_o,
                mem_write_data_o};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int sel;
        bit got;

        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("reset_outputs_zero", all_outputs(), 0);

        // Directed refill of 0x108 from an idle responder.
        refill(32'h108, lat);
        check("ack_latency", lat, 1);
        wait_drain();

        // Simultaneous snoop, writeback and refill: service order I, W, R.
        evlog.delete();
        fork
            snoop(32'h2040, 1);
            writeback(32'h1040, 32'h1234_5678);
            refill(32'h110, lat);
        join
        wait_drain();
        check("arb_count", evlog.size(), 3);
        if (evlog.size() == 3) begin
            check("arb_first", evlog[0], "I");
            check("arb_second", evlog[1], "W");
            check("arb_third", evlog[2], "R");
        end

        // Invalidate acknowledged 5 cycles after entry.
        inv_hi_cnt = 0; rdy_cnt = 0;
        snoop(32'h3000, 5);
        wait_drain();
        check("inv_high_cycles", inv_hi_cnt, 6);
        check("snoop_ready_pulses", rdy_cnt, 1);

        // Ack already present on entry.
        rdy_cnt = 0;
        snoop(32'h3004, 0);
        wait_drain();
        check("snoop_ready_immediate", rdy_cnt, 1);

        // Writeback of an unaligned address.
        wr_cnt = 0;
        writeback(32'h0000_0013, 32'hDEAD_BEEF);
        wait_drain();
        check("wb_busy_cycles", wr_cnt, 1);

        // Reset during the second data beat of a refill.
        @(posedge clk_i); #1;
        push_refill(32'h140);
        cache_request_i = 1'b1;
        cache_request_address_i = 32'h140;
        got = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk_i);
            if (cache_acknowledge_o) begin got = 1; break; end
        end
        if (!got) fail_now("reset_test_ack_timeout");
        @(posedge clk_i); #1;
        cache_request_i = 1'b0;
        @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        exp_beats.delete();
        exp_rdaddr.delete();
        beat_idx = 0;
        @(negedge clk_i);
        check("outputs_zero_after_reset", all_outputs(), 0);
        refill(32'h14C, lat);
        check("ack_latency_after_reset", lat, 1);
        wait_drain();

        // Randomised mixes of concurrent traffic.
        for (int it = 0; it < 40; it++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk_i);
            sel = $urandom_range(1, 7);
            fork
                if (sel[0]) refill(32'h100 + $urandom_range(0, 63) * 4 + $urandom_range(0, 3), lat);
                if (sel[1]) writeback(32'h1000 + $urandom_range(0, 4095), $urandom);
                if (sel[2]) snoop($urandom, $urandom_range(0, 3));
            join
        end
        wait_drain();

        check("beats_left", exp_beats.size(), 0);
        check("wb_left", exp_wb.size(), 0);
        check("snoop_left", exp_snoop.size(), 0);
        check("ack_count", ack_cnt, refill_cnt);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
